// File: rtl/core_run_pkg.sv
// Shared types and defaults for the core run controller.
// State encoding, parameter defaults and the result index width.
package core_run_pkg;

  localparam int DEF_WIDTH         = 32;
  localparam int DEF_NUM_VECTORS   = 4;
  localparam int DEF_RST_CYCLES    = 5;
  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_MAX_CYCLES    = 2000;
  localparam int IDX_W             = 4;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    REPORT,
    FINISH
  } state_t;

endpackage

// File: rtl/core_run_controller_out_stable.sv
// out_stable_detect: registered previous value plus a saturating
// count of consecutive unchanged cycles.
module out_stable_detect
  import core_run_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_val,
  output logic             o_stable
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_prev;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_val;
      if (i_clr || i_val != r_prev)
        r_cnt <= '0;
      else if (r_cnt != CMAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = (r_cnt == CMAX);

endmodule

// File: rtl/core_run_controller.sv
// Runs a core under test over a set of vectors and checks results.
// Define RUN_TIMEOUT_EN to bound each run by MAX_CYCLES.
module core_run_controller
  import core_run_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int NUM_VECTORS   = DEF_NUM_VECTORS,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_CYCLES    = DEF_MAX_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_VECTORS*WIDTH-1:0] sw_vec,
  input  logic [NUM_VECTORS*WIDTH-1:0] exp_vec,
  output logic                         core_rst,
  output logic [WIDTH-1:0]             core_sw,
  input  logic [WIDTH-1:0]             core_out,
  output logic                         busy,
  output logic                         result_valid,
  output logic [WIDTH-1:0]             result,
  output logic [IDX_W-1:0]             result_idx,
  output logic                         done,
  output logic                         pass,
  output logic [NUM_VECTORS-1:0]       fail_mask
);

  localparam int HCW = $clog2(RST_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VECTORS - 1);

  state_t r_state;
  state_t w_next;

  logic [HCW-1:0]         r_hcnt;
  logic [IDX_W-1:0]       r_idx;
  logic [WIDTH-1:0]       r_sw;
  logic [WIDTH-1:0]       r_result;
  logic [NUM_VECTORS-1:0] r_fail;
  logic                   r_pass;
  logic                   r_to;

  logic             w_clr;
  logic             w_stable;
  logic             w_timeout;
  logic             w_hold_end;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_exp;

  assign w_clr = (r_state != RUN);

  out_stable_detect #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stable (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_val   (core_out),
    .o_stable(w_stable)
  );

`ifdef RUN_TIMEOUT_EN
  localparam int TCW = $clog2(MAX_CYCLES + 1);
  localparam logic [TCW-1:0] TMAX = TCW'(MAX_CYCLES - 1);

  logic [TCW-1:0] r_tcnt;

  always_ff @(posedge clk) begin
    if (rst || w_clr)
      r_tcnt <= '0;
    else if (r_tcnt != TMAX)
      r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_timeout = (r_tcnt == TMAX);
`else
  logic w_unused_max;
  assign w_unused_max = MAX_CYCLES[0];
  assign w_timeout    = 1'b0;
`endif

  assign w_hold_end = (r_hcnt == HCW'(RST_CYCLES - 1));
  assign w_exp      = exp_vec[int'(r_idx) * WIDTH +: WIDTH];
  assign w_mismatch = (r_result != w_exp) || r_to;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    core_rst     = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy     = 1'b0;
        core_rst = 1'b1;
        if (start) w_next = HOLD;
      end
      HOLD: begin
        core_rst = 1'b1;
        if (w_hold_end) w_next = RUN;
      end
      RUN: begin
        if (w_stable || w_timeout) w_next = REPORT;
      end
      REPORT: begin
        result_valid = 1'b1;
        w_next = (r_idx == LAST) ? FINISH : HOLD;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt   <= '0;
      r_idx    <= '0;
      r_sw     <= '0;
      r_result <= '0;
      r_fail   <= '0;
      r_pass   <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_hcnt <= '0;
            r_idx  <= '0;
            r_fail <= '0;
            r_pass <= 1'b0;
            r_sw   <= sw_vec[WIDTH-1:0];
          end
        end
        HOLD: begin
          r_hcnt <= w_hold_end ? '0 : r_hcnt + 1'b1;
        end
        RUN: begin
          // Stability takes priority over a coincident timeout
          if (w_stable || w_timeout) begin
            r_result <= core_out;
            r_to     <= w_timeout && !w_stable;
          end
        end
        REPORT: begin
          r_fail <= r_fail | (NUM_VECTORS'(w_mismatch) << r_idx);
          if (r_idx != LAST) begin
            r_idx <= r_idx + 1'b1;
            r_sw  <= sw_vec[int'(r_idx + 1'b1) * WIDTH +: WIDTH];
          end
        end
        FINISH: begin
          r_pass <= ~|r_fail;
        end
        default: ;
      endcase
    end
  end

  assign core_sw    = r_sw;
  assign result     = r_result;
  assign result_idx = r_idx;
  assign pass       = r_pass;
  assign fail_mask  = r_fail;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller: a 1-vector and a 4-vector
// instance, each driving a small behavioural core model.
`timescale 1ns/1ps
module tb_core_run_controller;
  import core_run_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] ex;
    logic [W-1:0] res;
    logic         bad;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst1 = 1'b1;
  logic         start1 = 1'b0;
  logic [W-1:0] sw1 = 32'd5;
  logic [W-1:0] exp1 = 32'd120;
  logic         crst1, busy1, rv1, done1, pass1;
  logic [W-1:0] csw1, cout1, res1;
  logic [3:0]   idx1;
  logic [0:0]   fm1;

  logic           rst4 = 1'b1;
  logic           start4 = 1'b0;
  logic [4*W-1:0] sw4 = '0;
  logic [4*W-1:0] exp4 = '0;
  logic           crst4, busy4, rv4, done4, pass4;
  logic [W-1:0]   csw4, cout4, res4;
  logic [3:0]     idx4;
  logic [3:0]     fm4;

  int m1 = 0;
  int m4 = 0;
  int mode = 0;

  core_run_controller #(
    .WIDTH(W), .NUM_VECTORS(1), .RST_CYCLES(5),
    .STABLE_CYCLES(16), .MAX_CYCLES(2000)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1),
    .sw_vec(sw1), .exp_vec(exp1),
    .core_rst(crst1), .core_sw(csw1), .core_out(cout1),
    .busy(busy1), .result_valid(rv1), .result(res1),
    .result_idx(idx1), .done(done1), .pass(pass1),
    .fail_mask(fm1)
  );

  core_run_controller #(
    .WIDTH(W), .NUM_VECTORS(4), .RST_CYCLES(5),
    .STABLE_CYCLES(16), .MAX_CYCLES(200)
  ) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4),
    .sw_vec(sw4), .exp_vec(exp4),
    .core_rst(crst4), .core_sw(csw4), .core_out(cout4),
    .busy(busy4), .result_valid(rv4), .result(res4),
    .result_idx(idx4), .done(done4), .pass(pass4),
    .fail_mask(fm4)
  );

  function automatic logic [W-1:0] fact(input logic [W-1:0] n);
    logic [W-1:0] r = 1;
    for (int i = 2; i <= 12; i++)
      if (W'(i) <= n) r = r * W'(i);
    return r;
  endfunction

  // Core models: cycle count since core reset released
  always @(posedge clk) begin
    m1 <= crst1 ? 0 : m1 + 1;
    m4 <= crst4 ? 0 : m4 + 1;
  end

  assign cout1 = (m1 < 40) ? W'(m1) : fact(csw1);

  always_comb begin
    case (mode)
      0:       cout4 = (m4 < 40) ? W'(m4) : fact(csw4);
      1:       cout4 = W'((m4 / 10) % 2);
      2:       cout4 = (m4 >= 14) ? 32'd9 : 32'd7;
      default: cout4 = 32'd7;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int nrv, ndone, holdc, n;
  logic [W-1:0] gres [16];
  logic [3:0]   gidx [16];
  logic [W-1:0] r;
  logic [3:0]   efm;
  vec_t         tbl [4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, "_flags"}, {crst4, busy4, rv4, done4, pass4}, 5'b10000);
    chk({tag, "_fail_mask"}, fm4, 0);
    chk({tag, "_result"}, res4, 0);
    chk({tag, "_idx"}, idx4, 0);
    chk({tag, "_core_sw"}, csw4, 0);
  endtask

  task automatic pulse_rst4();
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic run4(input int budget, input bit poke);
    nrv = 0; ndone = 0; holdc = 0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < budget && ndone == 0; c++) begin
      if (busy4 && crst4) holdc++;
      if (rv4) begin
        if (nrv < 16) begin
          gres[nrv] = res4;
          gidx[nrv] = idx4;
        end
        nrv++;
      end
      if (done4) ndone++;
      start4 = poke && (c == 2 || c == 20);
      @(negedge clk);
    end
    start4 = 1'b0;
    repeat (100) begin
      if (done4) ndone++;
      if (rv4) nrv++;
      @(negedge clk);
    end
  endtask

  task automatic check_tbl(input string tag);
    chk({tag, "_rv_count"}, nrv, 4);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_hold_cycles"}, holdc, 20);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_res%0d", tag, i), gres[i], tbl[i].res);
      chk($sformatf("%s_idx%0d", tag, i), gidx[i], i);
    end
    chk({tag, "_fail_mask"}, fm4, efm);
    chk({tag, "_pass"}, pass4, ~|efm);
  endtask

  task automatic lat4(output int lat, output logic [W-1:0] rr);
    lat = -1;
    rr  = '0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 50 && crst4; c++) @(negedge clk);
    for (int c = 0; c < 6000; c++) begin
      if (rv4) begin
        lat = c;
        rr  = res4;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0] = '{sw: 1, ex: 1,  res: 1,  bad: 1'b0};
    tbl[1] = '{sw: 2, ex: 2,  res: 2,  bad: 1'b0};
    tbl[2] = '{sw: 3, ex: 99, res: 6,  bad: 1'b1};
    tbl[3] = '{sw: 4, ex: 24, res: 24, bad: 1'b0};
    for (int i = 0; i < 4; i++) begin
      sw4[i*W +: W]  = tbl[i].sw;
      exp4[i*W +: W] = tbl[i].ex;
      efm[i]         = tbl[i].bad;
    end

    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);
    chk_reset4("reset");
    chk("reset_dut1", {crst1, busy1, pass1, fm1}, 4'b1000);

    // Scenario 1: single factorial vector
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    holdc = 0; nrv = 0; ndone = 0; r = '0; gidx[0] = 4'hf;
    for (int c = 0; c < 400 && ndone == 0; c++) begin
      if (busy1 && crst1) holdc++;
      if (rv1) begin
        nrv++;
        r = res1;
        gidx[0] = idx1;
      end
      if (done1) ndone++;
      @(negedge clk);
    end
    chk("s1_hold_cycles", holdc, 5);
    chk("s1_rv_count", nrv, 1);
    chk("s1_result", r, 120);
    chk("s1_idx", gidx[0], 0);
    chk("s1_done", ndone, 1);
    chk("s1_pass", pass1, 1);
    chk("s1_idle", busy1, 0);

    // Scenario 2: table of four vectors, vector 2 expected wrong
    mode = 0;
    run4(600, 1'b0);
    check_tbl("s2");

    // Scenario 5: extra start pulses in HOLD and RUN
    run4(600, 1'b1);
    check_tbl("s5");

    // Scenario 4: reset in the 3rd RUN cycle of vector 1
    exp4[0 +: W] = 32'd77;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 200 && !rv4; c++) @(negedge clk);
    chk("s4_first_rv", rv4, 1);
    @(negedge clk);
    for (int c = 0; c < 20 && crst4; c++) @(negedge clk);
    chk("s4_in_run", {busy4, crst4, idx4}, {1'b1, 1'b0, 4'd1});
    repeat (2) @(negedge clk);
    chk("s4_fail_before", fm4, 4'b0001);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    chk_reset4("s4");
    ndone = 0;
    repeat (300) begin
      if (done4 || busy4) ndone++;
      @(negedge clk);
    end
    chk("s4_quiet", ndone, 0);
    exp4[0 +: W] = tbl[0].ex;

    // Scenario 6: stability window boundary
    mode = 3;
    lat4(n, r);
    chk("s6_base_latency", n, 16);
    chk("s6_base_result", r, 7);
    pulse_rst4();
    mode = 2;
    lat4(n, r);
    chk("s6_glitch_latency", n, 31);
    chk("s6_glitch_result", r, 9);
    pulse_rst4();

    // Scenario 3: core never settles
    mode = 1;
`ifdef RUN_TIMEOUT_EN
    lat4(n, r);
    chk("s3_timeout_latency", n, 200);
    chk("s3_timeout_result", r, 1);
    @(negedge clk);
    chk("s3_timeout_fail", fm4[0], 1);
`else
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0; nrv = 0;
    repeat (5000) begin
      if (busy4) n++;
      if (rv4) nrv++;
      @(negedge clk);
    end
    chk("s3_busy_held", n, 5000);
    chk("s3_no_result", nrv, 0);
`endif
    pulse_rst4();
    chk("s3_after_reset", busy4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_run_controller.md
CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of the core switch input and result output.
REQ-002 The block SHALL have parameter NUM_VECTORS, default 4, giving the number of test vectors run per campaign (range 1..16).
REQ-003 The block SHALL have parameter RST_CYCLES, default 5, giving the number of cycles the core is held in reset before each run (at least 1).
REQ-004 The block SHALL have parameter STABLE_CYCLES, default 16, giving the consecutive unchanged core_out cycles that declare a run finished (at least 2).
REQ-005 The block SHALL have parameter MAX_CYCLES, default 2000, giving the run cycle budget (used only when RUN_TIMEOUT_EN is defined).
REQ-006 The block SHALL have the following ports, with clock and reset first:
- clk, input, 1 -- the single clock; all logic is rising-edge.
- rst, input, 1 -- synchronous, active-high reset.
- start, input, 1 -- one-cycle pulse that begins a campaign; ignored when the block is not idle.
- sw_vec, input, NUM_VECTORS*WIDTH -- stimulus values; vector i is at bits [i*WIDTH +: WIDTH].
- exp_vec, input, NUM_VECTORS*WIDTH -- expected results, packed the same way as sw_vec.
- core_rst, output, 1 -- reset to the core under test.
- core_sw, output, WIDTH -- switch value to the core.
- core_out, input, WIDTH -- result from the core.
- busy, output, 1 -- high while a campaign is in progress.
- result_valid, output, 1 -- one-cycle pulse per completed vector.
- result, output, WIDTH -- the captured core_out for that vector.
- result_idx, output, 4 -- index of that vector.
- done, output, 1 -- one-cycle pulse at the end of a campaign.
- pass, output, 1 -- high when every vector in the last campaign matched.
- fail_mask, output, NUM_VECTORS -- bit i set when vector i mismatched or timed out.

Function
REQ-007 The block SHALL use the states IDLE, HOLD, RUN, REPORT and FINISH.
REQ-008 In IDLE, start SHALL clear the vector index, clear fail_mask, and go to HOLD on the next cycle.
REQ-009 In HOLD, core_rst SHALL be 1 and core_sw SHALL equal the current vector for exactly RST_CYCLES cycles, after which the state goes to RUN.
REQ-010 In RUN, core_rst SHALL be 0, core_sw SHALL stay fixed, and core_out SHALL be compared with its registered value from the previous cycle.
  - Each equal cycle increments the stability counter.
  - Any difference reloads the counter to 0.
REQ-011 When the stability counter reaches STABLE_CYCLES-1, the state SHALL go to REPORT with core_out captured into result.
REQ-012 In REPORT, the block SHALL pulse result_valid for exactly one cycle, with result_idx set to the current index.
  - fail_mask[idx] is set if result differs from the expected value for that vector.
  - If the index is the last one (NUM_VECTORS-1), the next state is FINISH.
  - Otherwise the index increments and the next state is HOLD.
REQ-013 In FINISH, the block SHALL pulse done for one cycle, set pass to ~|fail_mask, and return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 core_rst SHALL be 1 in IDLE.
REQ-016 pass and fail_mask SHALL hold their values until the next start or reset.
REQ-017 A start asserted during any non-IDLE state SHALL be ignored without side effects.
REQ-018 The stability counter and the timeout counter SHALL saturate and never wrap.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL reset as follows, regardless of state, including mid-run:
  - state goes to IDLE;
  - core_rst=1, core_sw=0;
  - busy, result_valid and done are 0;
  - result=0, result_idx=0;
  - pass=0, fail_mask=0;
  - all counters are 0.
REQ-020 After reset is released, the block SHALL require a fresh start pulse before beginning a campaign.

Configuration
REQ-021 With RUN_TIMEOUT_EN defined, RUN SHALL count cycles; reaching MAX_CYCLES without stability SHALL go to REPORT with result equal to the current core_out and fail_mask[idx] forced to 1.
  - If stability and timeout occur on the same cycle, stability wins and the normal compare applies.
REQ-022 Without RUN_TIMEOUT_EN, the timeout counter SHALL be absent, and RUN SHALL leave only on stability or reset.

Structure
REQ-023 A shared package core_run_pkg SHALL hold:
  - the state encoding constants;
  - the default values of WIDTH, NUM_VECTORS, RST_CYCLES, STABLE_CYCLES and MAX_CYCLES;
  - the width of result_idx.
REQ-024 The stability detector (registered previous value plus saturating counter, with a clear input and a stable output) SHALL be a sub-module named out_stable_detect.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Scenario 1: NUM_VECTORS=1, sw_vec=5, exp_vec=120, and a core model whose output settles to sw! (factorial) after 40 cycles.
    - core_rst is high for exactly 5 cycles.
    - One result_valid pulse with result=120 and idx=0.
    - A done pulse, then pass=1.
  - Scenario 2: 4 vectors, with exp_vec for vector 2 deliberately wrong.
    - 4 result_valid pulses with idx 0..3 in order.
    - fail_mask=4'b0100 and pass=0.
  - Scenario 3: A core whose output toggles every 10 cycles with STABLE_CYCLES=16.
    - With RUN_TIMEOUT_EN and MAX_CYCLES=200, result_valid fires exactly 200 RUN cycles after entering RUN, and fail_mask[0]=1.
    - Without the macro, busy stays 1 for 5000 cycles.
  - Scenario 4: rst asserted in the 3rd RUN cycle of vector 1.
    - On the next cycle, all outputs equal their reset values.
    - No done pulse follows.
  - Scenario 5: start pulsed again during HOLD and during RUN.
    - The campaign is unaffected, with one done pulse and identical results.
  - Scenario 6: Output changes at exactly cycle STABLE_CYCLES-1 of a stable window.
    - The counter reloads, and capture occurs only after a further 16 stable cycles.
